// File: rtl/sprite_pkg.sv
// Shared types and helpers for the multi-sprite bouncing animator.
// FSM state encoding, coordinate saturation and reflection magnitude.
// Pure declarations; no logic of its own.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Clamp a coordinate into [lo, hi].
  function automatic int sat_coord(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return r;
  endfunction

  // Speed used after a bounce: |v|, with the most-negative code limited
  // to the largest positive magnitude so the sign flip stays representable.
  function automatic int refl_mag(input int v, input int vw);
    int m;
    int lim;
    lim = (1 << (vw - 1)) - 1;
    m   = (v < 0) ? -v : v;
    if (m > lim) m = lim;
    return m;
  endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis position/velocity step: pos+vel, then reflect (or wrap) at the bounds.
// Purely combinational, zero latency.
// No flow control; the caller decides when to commit the result. Wrap via SPRITE_BOUNCE_WRAP_EN.
module axis_step
  import sprite_pkg::*;
#(
  parameter int CW = 12,
  parameter int VW = 4
) (
  input  logic [CW-1:0]        i_pos,
  input  logic signed [VW-1:0] i_vel,
  input  logic [CW-1:0]        i_lo,
  input  logic [CW-1:0]        i_hi,
`ifdef SPRITE_BOUNCE_WRAP_EN
  input  logic                 i_wrap,
`endif
  output logic [CW-1:0]        o_pos,
  output logic signed [VW-1:0] o_vel
);

  int p, v, n, lo, hi, m;

  // Next position; out-of-range results bounce off (or wrap past) the bound.
  always_comb begin
    p     = int'(i_pos);
    v     = int'(i_vel);
    lo    = int'(i_lo);
    hi    = int'(i_hi);
    n     = p + v;
    m     = refl_mag(v, VW);
    o_pos = CW'(n);
    o_vel = i_vel;
`ifdef SPRITE_BOUNCE_WRAP_EN
    if (i_wrap) begin
      if (n < lo)      o_pos = CW'(n + (hi - lo + 1));
      else if (n > hi) o_pos = CW'(n - (hi - lo + 1));
    end else
`endif
    begin
      if (n < lo) begin
        o_pos = i_lo;
        o_vel = VW'(m);
      end else if (n > hi) begin
        o_pos = i_hi;
        o_vel = VW'(-m);
      end
    end
  end

endmodule

// File: rtl/sprite_bounce.sv
// N_SPR bouncing rectangles; each strobe sweeps one sprite per clock and reflects off edges.
// Sprite k edges update T+2+k after strobe T; done pulses at T+N_SPR+1; loads visible next cycle.
// Strobes while busy are dropped (o_missed pulses next cycle); loads only taken in IDLE. Wrap via SPRITE_BOUNCE_WRAP_EN.
module sprite_bounce
  import sprite_pkg::*;
#(
  parameter int N_SPR    = 4,
  parameter int W_HALF   = 16,
  parameter int H_HALF   = 16,
  parameter int D_WIDTH  = 640,
  parameter int D_HEIGHT = 480,
  parameter int CW       = 12,
  parameter int VW       = 4
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_ani_stb,
  input  logic                                            i_animate,
  input  logic                                            i_load,
  input  logic [((N_SPR > 1) ? $clog2(N_SPR) : 1)-1:0]    i_load_id,
  input  logic [CW-1:0]                                   i_load_x,
  input  logic [CW-1:0]                                   i_load_y,
  input  logic signed [VW-1:0]                            i_load_vx,
  input  logic signed [VW-1:0]                            i_load_vy,
`ifdef SPRITE_BOUNCE_WRAP_EN
  input  logic                                            i_wrap,
`endif
  output logic [N_SPR*CW-1:0]                             o_x1,
  output logic [N_SPR*CW-1:0]                             o_x2,
  output logic [N_SPR*CW-1:0]                             o_y1,
  output logic [N_SPR*CW-1:0]                             o_y2,
  output logic                                            o_busy,
  output logic                                            o_done,
  output logic                                            o_missed
);

  localparam int IDW  = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  localparam int XMIN = W_HALF;
  localparam int XMAX = D_WIDTH - 1 - W_HALF;
  localparam int YMIN = H_HALF;
  localparam int YMAX = D_HEIGHT - 1 - H_HALF;
  localparam logic [CW-1:0] XMIN_C = CW'(XMIN);
  localparam logic [CW-1:0] XMAX_C = CW'(XMAX);
  localparam logic [CW-1:0] YMIN_C = CW'(YMIN);
  localparam logic [CW-1:0] YMAX_C = CW'(YMAX);
  localparam logic [CW-1:0] X_RST  = CW'(D_WIDTH / 2);
  localparam logic [CW-1:0] Y_RST  = CW'(D_HEIGHT / 2);
  localparam logic signed [VW-1:0] V_RST = VW'(1);

  state_e             state_q, state_d;
  logic [IDW-1:0]     idx_q, idx_d;
  logic               missed_q, missed_d;
  logic [CW-1:0]      x_q[N_SPR], x_d[N_SPR], y_q[N_SPR], y_d[N_SPR];
  logic signed [VW-1:0] vx_q[N_SPR], vx_d[N_SPR], vy_q[N_SPR], vy_d[N_SPR];
  logic [CW-1:0]      x1_q[N_SPR], x2_q[N_SPR], y1_q[N_SPR], y2_q[N_SPR];
  logic [CW-1:0]      x1_d[N_SPR], x2_d[N_SPR], y1_d[N_SPR], y2_d[N_SPR];
  logic [CW-1:0]      nx, ny;
  logic signed [VW-1:0] nvx, nvy;

  axis_step #(.CW(CW), .VW(VW)) u_step_x (
    .i_pos (x_q[idx_q]),
    .i_vel (vx_q[idx_q]),
    .i_lo  (XMIN_C),
    .i_hi  (XMAX_C),
`ifdef SPRITE_BOUNCE_WRAP_EN
    .i_wrap(i_wrap),
`endif
    .o_pos (nx),
    .o_vel (nvx)
  );

  axis_step #(.CW(CW), .VW(VW)) u_step_y (
    .i_pos (y_q[idx_q]),
    .i_vel (vy_q[idx_q]),
    .i_lo  (YMIN_C),
    .i_hi  (YMAX_C),
`ifdef SPRITE_BOUNCE_WRAP_EN
    .i_wrap(i_wrap),
`endif
    .o_pos (ny),
    .o_vel (nvy)
  );

  // Sweep sequencing, load handling and dropped-strobe detection.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    missed_d = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    case (state_q)
      ST_IDLE: begin
        if (i_load && (int'(i_load_id) < N_SPR)) begin
          x_d[i_load_id]  = CW'(sat_coord(int'(i_load_x), XMIN, XMAX));
          y_d[i_load_id]  = CW'(sat_coord(int'(i_load_y), YMIN, YMAX));
          vx_d[i_load_id] = i_load_vx;
          vy_d[i_load_id] = i_load_vy;
        end
        if (i_ani_stb && i_animate) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        x_d[idx_q]  = nx;
        y_d[idx_q]  = ny;
        vx_d[idx_q] = nvx;
        vy_d[idx_q] = nvy;
        missed_d    = i_ani_stb && i_animate;
        if (idx_q == IDW'(N_SPR - 1)) state_d = ST_DONE;
        else                          idx_d   = idx_q + IDW'(1);
      end
      ST_DONE: begin
        missed_d = i_ani_stb && i_animate;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge coordinates derived from the next stored centres so they register alongside them.
  always_comb begin
    for (int k = 0; k < N_SPR; k++) begin
      x1_d[k] = x_d[k] - CW'(W_HALF);
      x2_d[k] = x_d[k] + CW'(W_HALF);
      y1_d[k] = y_d[k] - CW'(H_HALF);
      y2_d[k] = y_d[k] + CW'(H_HALF);
    end
  end

  // State registers; reset parks every sprite at screen centre moving down-right.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      missed_q <= 1'b0;
      for (int k = 0; k < N_SPR; k++) begin
        x_q[k]  <= X_RST;
        y_q[k]  <= Y_RST;
        vx_q[k] <= V_RST;
        vy_q[k] <= V_RST;
        x1_q[k] <= X_RST - CW'(W_HALF);
        x2_q[k] <= X_RST + CW'(W_HALF);
        y1_q[k] <= Y_RST - CW'(H_HALF);
        y2_q[k] <= Y_RST + CW'(H_HALF);
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      missed_q <= missed_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
    end
  end

  for (genvar k = 0; k < N_SPR; k++) begin : g_pack
    assign o_x1[k*CW +: CW] = x1_q[k];
    assign o_x2[k*CW +: CW] = x2_q[k];
    assign o_y1[k*CW +: CW] = y1_q[k];
    assign o_y2[k*CW +: CW] = y2_q[k];
  end

  assign o_busy   = (state_q == ST_SWEEP);
  assign o_done   = (state_q == ST_DONE);
  assign o_missed = missed_q;

endmodule
